pwm_spi_regs: RTL
=================

Name: pwm_spi_regs

Overview:
SPI-slave register bank that sits directly upstream of the PWM Timer channels in the IO expander. It receives 24-bit command frames from the host MCU and holds per-channel shadow Prescaler/Count/SwitchValue registers. On a commit command it transfers all shadows atomically into the active registers that drive the Timer inputs, and issues a one-cycle load strobe. It also supports shadow readback over MISO.

Parameters:
NUM_CH, 4, number of PWM channels; legal values 1..4, selected by cmd[1:0].
DW, 16, width of the Prescaler/Count/SwitchValue fields; fixed by the 16-bit frame data phase.

Ports:
CLK  in  1  system clock, shared with the Timers.
RST  in  1  asynchronous reset, active-high.
SCK  in  1  SPI clock, mode 0, asynchronous to CLK; f_CLK >= 8*f_SCK.
CS_N  in  1  SPI chip select, active-low, asynchronous.
MOSI  in  1  SPI data in, MSB first.
MISO  out  1  SPI data out; driven 0 when CS_N is high.
Prescaler  out  NUM_CH*DW  active prescaler per channel; channel n at [n*DW +: DW].
Count  out  NUM_CH*DW  active period count per channel.
SwitchValue  out  NUM_CH*DW  active compare value per channel.
ChEnable  out  NUM_CH  active channel-enable mask.
Load  out  1  one-CLK pulse on the cycle the active registers update.
CfgErr  out  1  sticky flag: some enabled channel has SwitchValue > Count after a commit.

Behaviour:
- Sync: SCK, CS_N and MOSI each pass through a 2-flop synchronizer. Edge detect runs on the synced SCK. All logic runs in the CLK domain.
- Frame: 24 bits MSB first, sampled on SCK rising. Bits 23:16 are the command, bits 15:0 are the data.
- Command fields: cmd[7] = 1 for write, 0 for read. cmd[6:4] reserved, ignored. cmd[3:2] selects the register: 0 Prescaler, 1 Count, 2 SwitchValue, 3 Control. cmd[1:0] selects the channel.
- FSM states:
  - IDLE: CS_N high. Counters cleared. Frame begins on synced CS_N falling.
  - CMD: count 8 rising edges, then go to DATA.
  - DATA: count 16 rising edges, then go to DONE.
  - DONE: ignore further SCK edges until CS_N rises.
  - Synced CS_N rising in any state returns the FSM to IDLE.
- Write action: performed on the first CLK after the 24th rising edge.
  - reg 0..2: write data into the shadow register of the selected channel.
  - reg 3 (Control): data[NUM_CH-1:0] goes to the ChEnable shadow. If data[15] = 1, commit.
- Commit: on the next CLK, all shadows (including the enable mask) copy into the active registers, Load is high for exactly that cycle, and CfgErr is set if any enabled channel has SwitchValue > Count. CfgErr clears only on a Control write with data[14] = 1.
- Channel index >= NUM_CH: the write is discarded and the read returns 0.
- Read: after the 8th rising edge, the shadow of the selected register/channel (Control reads {CfgErr, 15'b0, ChEnable shadow} truncated to 16 bits, i.e. {CfgErr,…,ChEnable}) loads into the TX shift register. MISO presents its MSB. The register shifts on each synced SCK falling edge. During CMD, MISO = 0.
- Aborted frame: CS_N rises before the 24th bit. No register changes and no commit.
- Bits beyond 24: ignored.
- Commit and a new frame in the same cycle: the commit uses the shadows as they were before that frame's write.
- Reset (asynchronous, any time, including mid-frame):
  - all shadows and active registers = 0; ChEnable = 0.
  - Load = 0, CfgErr = 0, MISO = 0.
  - FSM returns to IDLE. A partial frame is lost.
- Width: all fields are exactly DW bits, with no arithmetic beyond the single compare.

Decomposition:
- Shared package: register-select constants (REG_PRESC=0, REG_COUNT=1, REG_SWITCH=2, REG_CTRL=3), control bit positions (COMMIT=15, CLR_ERR=14), FRAME_BITS=24, CMD_BITS=8, FSM state enum.
- Sub-module: spi_frontend, containing the synchronizers, edge detect, bit counter, RX/TX shifters and FSM. It emits cmd/data plus a frame_done pulse and takes rd_data in. The top holds the register bank and commit logic.

Test Plan:
- Write ch0: Prescaler=15, Count=6000, SwitchValue=1500, then Control=0x8001. -> Load pulses once. Prescaler[15:0]=15, Count[15:0]=6000, SwitchValue[15:0]=1500, ChEnable=0001. Active outputs unchanged before the commit.
- Shadow-only update: write ch0 Count=3000, SwitchValue=1500 with no commit. -> Active registers keep 6000/1500 and Load stays 0. Control=0x8001 -> Count=3000.
- Readback: read ch0 Count (cmd 0x04). -> MISO shifts 0x0BB8 MSB first over data bits 15:0.
- Abort: raise CS_N after 12 bits of a write to ch1 Prescaler. -> Shadow unchanged (read returns 0) and no Load.
- Error: ch2 Count=100, SwitchValue=200, Control=0x8004. -> CfgErr=1. Control=0x4004 -> CfgErr=0.
- Reset mid-frame: assert RST during the DATA phase. -> All outputs 0 immediately. A subsequent full frame decodes correctly.

Source files
------------

// File: rtl/pwm_spi_regs_pkg.sv
// Shared constants and FSM encoding for the PWM SPI register bank.
package pwm_spi_regs_pkg;
  localparam logic [1:0] REG_PRESC  = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_SWITCH = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int COMMIT     = 15;
  localparam int CLR_ERR    = 14;
  localparam int FRAME_BITS = 24;
  localparam int CMD_BITS   = 8;
  localparam int DATA_BITS  = FRAME_BITS - CMD_BITS;

  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA, ST_DONE} state_t;
endpackage

// File: rtl/pwm_spi_regs_spi_frontend.sv
// SPI mode-0 slave front end: synchronizers, edge detect, frame FSM, RX/TX shifters.
module spi_frontend
  import pwm_spi_regs_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sck_i,
  input  logic                cs_n_i,
  input  logic                mosi_i,
  output logic                miso_o,
  output logic [CMD_BITS-1:0] cmd_o,
  output logic [DW-1:0]       data_o,
  output logic                frame_done_o,
  input  logic [DW-1:0]       rd_data_i
);
  logic [1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic sck_prev_q, cs_prev_q;
  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  state_t state_q;
  logic [4:0] cnt_q;
  logic [CMD_BITS-1:0] cmd_q;
  logic [DW-1:0] rx_q, tx_q;
  logic tx_ld_q, done_q;

  assign sck_s    = sck_sync_q[1];
  assign cs_s     = cs_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync_q  <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      tx_ld_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], sck_i};
      cs_sync_q   <= {cs_sync_q[0], cs_n_i};
      mosi_sync_q <= {mosi_sync_q[0], mosi_i};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
      done_q      <= 1'b0;
      tx_ld_q     <= 1'b0;
      // cmd_q settles one cycle before the TX load so rd_data_i reflects it
      if (tx_ld_q) tx_q <= rd_data_i;
      if (cs_rise) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        tx_q    <= '0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            cnt_q <= '0;
            tx_q  <= '0;
            if (cs_fall) state_q <= ST_CMD;
          end
          ST_CMD: if (sck_rise) begin
            cmd_q <= {cmd_q[CMD_BITS-2:0], mosi_s};
            if (cnt_q == 5'(CMD_BITS-1)) begin
              cnt_q   <= '0;
              state_q <= ST_DATA;
              tx_ld_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
          ST_DATA: begin
            if (sck_rise) begin
              rx_q  <= {rx_q[DW-2:0], mosi_s};
              cnt_q <= cnt_q + 5'd1;
              if (cnt_q == 5'(DATA_BITS-1)) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end else if (sck_fall && cnt_q != '0) begin
              // first falling edge keeps the MSB up for the first data sample
              tx_q <= {tx_q[DW-2:0], 1'b0};
            end
          end
          ST_DONE: ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign miso_o       = tx_q[DW-1] & ((state_q == ST_DATA) | (state_q == ST_DONE));
  assign cmd_o        = cmd_q;
  assign data_o       = rx_q;
  assign frame_done_o = done_q;
endmodule

// File: rtl/pwm_spi_regs.sv
// Shadow/active register bank for the PWM timers, written over SPI, committed atomically.
module pwm_spi_regs
  import pwm_spi_regs_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DW     = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SCK,
  input  logic                 CS_N,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [NUM_CH*DW-1:0] Prescaler,
  output logic [NUM_CH*DW-1:0] Count,
  output logic [NUM_CH*DW-1:0] SwitchValue,
  output logic [NUM_CH-1:0]    ChEnable,
  output logic                 Load,
  output logic                 CfgErr
);
  logic [CMD_BITS-1:0] cmd;
  logic [DW-1:0] data, rd_data;
  logic frame_done;

  spi_frontend #(.DW(DW)) u_fe (
    .clk_i        (CLK),
    .rst_i        (RST),
    .sck_i        (SCK),
    .cs_n_i       (CS_N),
    .mosi_i       (MOSI),
    .miso_o       (MISO),
    .cmd_o        (cmd),
    .data_o       (data),
    .frame_done_o (frame_done),
    .rd_data_i    (rd_data)
  );

  logic [NUM_CH-1:0][DW-1:0] presc_sh_q, cnt_sh_q, sw_sh_q;
  logic [NUM_CH-1:0][DW-1:0] presc_a_q, cnt_a_q, sw_a_q;
  logic [NUM_CH-1:0] en_sh_q, en_a_q, ch_hit, bad;
  logic commit_q, load_q, err_q, err_d;
  logic [1:0] sel, ch;
  logic wr_ok, ctrl_wr, clr_err;
  logic unused_bits;

  assign sel = cmd[3:2];
  assign ch  = cmd[1:0];
  assign unused_bits = ^{cmd[6:4], data[CLR_ERR-1:NUM_CH]};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign ch_hit[c] = (ch == 2'(c));
    assign bad[c]    = en_sh_q[c] & (sw_sh_q[c] > cnt_sh_q[c]);
  end

  assign wr_ok   = frame_done & cmd[7] & (|ch_hit);
  assign ctrl_wr = wr_ok & (sel == REG_CTRL);
  assign clr_err = ctrl_wr & data[CLR_ERR];
  assign err_d   = (err_q & ~clr_err) | (commit_q & (|bad));

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_hit[c]) begin
        unique case (sel)
          REG_PRESC:  rd_data = presc_sh_q[c];
          REG_COUNT:  rd_data = cnt_sh_q[c];
          REG_SWITCH: rd_data = sw_sh_q[c];
          default:    rd_data = {err_q, {(DW-1-NUM_CH){1'b0}}, en_sh_q};
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      presc_sh_q <= '0;
      cnt_sh_q   <= '0;
      sw_sh_q    <= '0;
      en_sh_q    <= '0;
      presc_a_q  <= '0;
      cnt_a_q    <= '0;
      sw_a_q     <= '0;
      en_a_q     <= '0;
      commit_q   <= 1'b0;
      load_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      load_q   <= commit_q;
      commit_q <= ctrl_wr & data[COMMIT];
      err_q    <= err_d;
      // nonblocking copy: a write landing in the commit cycle misses this commit
      if (commit_q) begin
        presc_a_q <= presc_sh_q;
        cnt_a_q   <= cnt_sh_q;
        sw_a_q    <= sw_sh_q;
        en_a_q    <= en_sh_q;
      end
      if (wr_ok) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (ch_hit[c]) begin
            unique case (sel)
              REG_PRESC:  presc_sh_q[c] <= data;
              REG_COUNT:  cnt_sh_q[c]   <= data;
              REG_SWITCH: sw_sh_q[c]    <= data;
              default:    ;
            endcase
          end
        end
        if (ctrl_wr) en_sh_q <= data[NUM_CH-1:0];
      end
    end
  end

  assign Prescaler   = presc_a_q;
  assign Count       = cnt_a_q;
  assign SwitchValue = sw_a_q;
  assign ChEnable    = en_a_q;
  assign Load        = load_q;
  assign CfgErr      = err_q;
endmodule
